// File: rtl/scpu_mem_pkg.sv
// Shared constants for the CPU-to-memory sequencer: bus widths, byte lanes, FSM states.
package scpu_mem_pkg;

    localparam int unsigned DEF_ADDR_W = 16;
    localparam int unsigned DEF_DATA_W = 8;

    localparam int unsigned LANE_LO = 0;
    localparam int unsigned LANE_HI = 1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD0  = 3'd1,
        RD1  = 3'd2,
        RD2  = 3'd3,
        WR0  = 3'd4,
        WR1  = 3'd5,
        DONE = 3'd6
    } state_e;

endpackage

// File: rtl/mem_ctrl_if.sv
// CPU-side request/response channel of the memory sequencer.
interface mem_ctrl_if #(
    parameter int unsigned ADDR_W = scpu_mem_pkg::DEF_ADDR_W,
    parameter int unsigned DATA_W = scpu_mem_pkg::DEF_DATA_W
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic                  req_word;
    logic [ADDR_W-1:0]     req_addr;
    logic [2*DATA_W-1:0]   req_wdata;
    logic                  rsp_valid;
    logic [2*DATA_W-1:0]   rsp_rdata;

    modport master (
        output req_valid, req_we, req_word, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_word, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/mem_ctrl.sv
// Sequences CPU byte/word requests onto a byte-wide synchronous memory,
// splitting words into little-endian byte pairs and absorbing the 1-cycle read latency.
module mem_ctrl
    import scpu_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    mem_ctrl_if.slave         cpu,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ce,
    output logic              mem_w,
    output logic              mem_r,
    output logic              mem_oe,
    output logic              mem_rst
);

    localparam int unsigned WORD_W = 2 * DATA_W;

    state_e              state_q, state_d;
    logic                word_q, word_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [WORD_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   lo_q, lo_d;
    logic [WORD_W-1:0]   rdata_q, rdata_d;
    logic                ready_q, ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                ce_q, ce_d;
    logic                w_q, w_d;
    logic                r_q, r_d;
    logic [ADDR_W-1:0]   maddr_q, maddr_d;
    logic [DATA_W-1:0]   mwdata_q, mwdata_d;
    logic [ADDR_W-1:0]   addr_inc;

    // State, latched request and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            word_q      <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            lo_q        <= '0;
            rdata_q     <= '0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            ce_q        <= 1'b0;
            w_q         <= 1'b0;
            r_q         <= 1'b0;
            maddr_q     <= '0;
            mwdata_q    <= '0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            lo_q        <= lo_d;
            rdata_q     <= rdata_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            ce_q        <= ce_d;
            w_q         <= w_d;
            r_q         <= r_d;
            maddr_q     <= maddr_d;
            mwdata_q    <= mwdata_d;
        end
    end

    // Next state, then memory pin values for the state being entered
    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        lo_d        = lo_q;
        rdata_d     = rdata_q;
        ce_d        = 1'b0;
        w_d         = 1'b0;
        r_d         = 1'b0;
        maddr_d     = maddr_q;
        mwdata_d    = mwdata_q;

        unique case (state_q)
            IDLE: begin
                if (cpu.req_valid) begin
                    word_d  = cpu.req_word;
                    addr_d  = cpu.req_addr;
                    wdata_d = cpu.req_wdata;
                    state_d = cpu.req_we ? WR0 : RD0;
                end
            end
            RD0: state_d = RD1;
            RD1: begin
                lo_d = mem_rdata;
                if (word_q) begin
                    state_d = RD2;
                end else begin
                    state_d = DONE;
                    rdata_d = '0;
                    rdata_d[LANE_LO*DATA_W +: DATA_W] = mem_rdata;
                end
            end
            RD2: begin
                state_d = DONE;
                rdata_d[LANE_LO*DATA_W +: DATA_W] = lo_q;
                rdata_d[LANE_HI*DATA_W +: DATA_W] = mem_rdata;
            end
            WR0:     state_d = word_q ? WR1 : DONE;
            WR1:     state_d = DONE;
            default: state_d = IDLE;
        endcase

        addr_inc    = addr_d + ADDR_W'(1);
        ready_d     = (state_d == IDLE);
        rsp_valid_d = (state_d == DONE);

        unique case (state_d)
            RD0: begin
                ce_d    = 1'b1;
                r_d     = 1'b1;
                maddr_d = addr_d;
            end
            RD1: begin
                if (word_d) begin
                    ce_d    = 1'b1;
                    r_d     = 1'b1;
                    maddr_d = addr_inc;
                end
            end
            WR0: begin
                ce_d     = 1'b1;
                w_d      = 1'b1;
                maddr_d  = addr_d;
                mwdata_d = wdata_d[LANE_LO*DATA_W +: DATA_W];
            end
            WR1: begin
                ce_d     = 1'b1;
                w_d      = 1'b1;
                maddr_d  = addr_inc;
                mwdata_d = wdata_d[LANE_HI*DATA_W +: DATA_W];
            end
            default: ;
        endcase
    end

    // Every output is forced to its reset value in any cycle with rst low
    assign cpu.req_ready = ready_q & rst;
    assign cpu.rsp_valid = rsp_valid_q & rst;
    assign cpu.rsp_rdata = rst ? rdata_q : '0;
    assign mem_addr      = rst ? maddr_q : '0;
    assign mem_wdata     = rst ? mwdata_q : '0;
    assign mem_ce        = ce_q & rst;
    assign mem_w         = w_q & rst;
    assign mem_r         = r_q & rst;
    assign mem_oe        = rst;
    assign mem_rst       = ~rst;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl driving a behavioural byte-wide registered-read memory.
module tb_mem_ctrl;

    logic        clk;
    logic        rst;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ce, mem_w, mem_r, mem_oe, mem_rst;

    mem_ctrl_if #(.ADDR_W(16), .DATA_W(8)) cpu ();

    mem_ctrl #(.ADDR_W(16), .DATA_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu       (cpu),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ce    (mem_ce),
        .mem_w     (mem_w),
        .mem_r     (mem_r),
        .mem_oe    (mem_oe),
        .mem_rst   (mem_rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural memory: writes and registered read on the rising edge
    logic [7:0]  mem_arr [0:65535];
    logic [7:0]  mem_out;
    logic [15:0] wlog_a [$];
    logic [7:0]  wlog_d [$];
    always @(posedge clk) begin
        if (mem_rst) mem_out <= 8'h00;
        else if (mem_ce && mem_r) mem_out <= mem_arr[mem_addr];
        if (!mem_rst && mem_ce && mem_w) begin
            mem_arr[mem_addr] <= mem_wdata;
            wlog_a.push_back(mem_addr);
            wlog_d.push_back(mem_wdata);
        end
    end
    assign mem_rdata = mem_oe ? mem_out : 8'h00;

    logic both_err = 1'b0;
    always @(negedge clk) if (mem_w && mem_r) both_err <= 1'b1;

    int          npass  = 0;
    int          ntotal = 0;
    logic [15:0] got_rdata;
    int          base;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One request from IDLE; checks ready, latency and single-cycle response
    task automatic do_req(input logic we, input logic word, input logic [15:0] a,
                          input logic [15:0] wd, input int lat, input string tag);
        int n;
        cpu.req_we    = we;
        cpu.req_word  = word;
        cpu.req_addr  = a;
        cpu.req_wdata = wd;
        cpu.req_valid = 1'b1;
        chk({tag, "_ready_idle"}, 32'(cpu.req_ready), 32'd1);
        tick();
        cpu.req_valid = 1'b0;
        n = 1;
        while (cpu.rsp_valid !== 1'b1 && n < 12) begin
            chk({tag, "_ready_busy"}, 32'(cpu.req_ready), 32'd0);
            tick();
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'(lat));
        chk({tag, "_ready_done"}, 32'(cpu.req_ready), 32'd0);
        got_rdata = cpu.rsp_rdata;
        tick();
        chk({tag, "_rsp_pulse"}, 32'(cpu.rsp_valid), 32'd0);
    endtask

    initial begin
        rst           = 1'b0;
        cpu.req_valid = 1'b0;
        cpu.req_we    = 1'b0;
        cpu.req_word  = 1'b0;
        cpu.req_addr  = 16'h0000;
        cpu.req_wdata = 16'h0000;

        // Reset state
        tick();
        tick();
        chk("rst_ready",   32'(cpu.req_ready), 32'd0);
        chk("rst_rsp",     32'(cpu.rsp_valid), 32'd0);
        chk("rst_rdata",   32'(cpu.rsp_rdata), 32'h0);
        chk("rst_ce",      32'(mem_ce),        32'd0);
        chk("rst_oe",      32'(mem_oe),        32'd0);
        chk("rst_memrst",  32'(mem_rst),       32'd1);
        rst = 1'b1;
        #1;
        chk("post_ready",  32'(cpu.req_ready), 32'd1);
        chk("post_oe",     32'(mem_oe),        32'd1);
        chk("post_memrst", 32'(mem_rst),       32'd0);

        // Byte write then byte read
        do_req(1'b1, 1'b0, 16'h0010, 16'h005A, 2, "bw10");
        chk("mem_10", 32'(mem_arr[16'h0010]), 32'h5A);
        do_req(1'b0, 1'b0, 16'h0010, 16'h0000, 3, "br10");
        chk("br10_data", 32'(got_rdata), 32'h005A);

        // Word write then word read
        do_req(1'b1, 1'b1, 16'h0020, 16'hBEEF, 3, "ww20");
        chk("mem_20", 32'(mem_arr[16'h0020]), 32'hEF);
        chk("mem_21", 32'(mem_arr[16'h0021]), 32'hBE);
        do_req(1'b0, 1'b1, 16'h0020, 16'h0000, 4, "wr20");
        chk("wr20_data", 32'(got_rdata), 32'hBEEF);

        // Byte read after word read: no high-byte carry-over
        do_req(1'b0, 1'b0, 16'h0010, 16'h0000, 3, "br10b");
        chk("br10b_data", 32'(got_rdata), 32'h005A);

        // A write leaves the last read result in place
        do_req(1'b1, 1'b0, 16'h0030, 16'h0077, 2, "bw30");
        chk("rdata_hold", 32'(cpu.rsp_rdata), 32'h005A);

        // Word write at the top of the address space wraps to 0000
        base = wlog_a.size();
        do_req(1'b1, 1'b1, 16'hFFFF, 16'hA1B2, 3, "wwff");
        chk("wrap_log_n", 32'(wlog_a.size() - base), 32'd2);
        chk("wrap_a0", 32'(wlog_a[base]),   32'hFFFF);
        chk("wrap_d0", 32'(wlog_d[base]),   32'hB2);
        chk("wrap_a1", 32'(wlog_a[base+1]), 32'h0000);
        chk("wrap_d1", 32'(wlog_d[base+1]), 32'hA1);
        do_req(1'b0, 1'b1, 16'hFFFF, 16'h0000, 4, "wrff");
        chk("wrff_data", 32'(got_rdata), 32'hA1B2);

        // req_valid held high: byte write then byte read, repeated
        cpu.req_valid = 1'b1;
        for (int k = 0; k < 14; k++) begin
            if (k % 7 == 0) begin
                cpu.req_we    = 1'b1;
                cpu.req_word  = 1'b0;
                cpu.req_addr  = 16'h0050 + 16'(k / 7);
                cpu.req_wdata = 16'h00C0 + 16'(k / 7);
            end else if (k % 7 == 3) begin
                cpu.req_we    = 1'b0;
            end
            #1;
            chk("b2b_ready", 32'(cpu.req_ready), 32'((k % 7 == 0) || (k % 7 == 3)));
            chk("b2b_rsp",   32'(cpu.rsp_valid), 32'((k % 7 == 2) || (k % 7 == 6)));
            if (k % 7 == 6)
                chk("b2b_rdata", 32'(cpu.rsp_rdata), 32'h00C0 + 32'(k / 7));
            if (k == 13) cpu.req_valid = 1'b0;
            tick();
        end
        chk("w_r_exclusive", 32'(both_err), 32'd0);

        // Reset asserted during WR1 of a word write
        do_req(1'b1, 1'b1, 16'h0040, 16'h0000, 3, "clr40");
        cpu.req_we    = 1'b1;
        cpu.req_word  = 1'b1;
        cpu.req_addr  = 16'h0040;
        cpu.req_wdata = 16'h1234;
        cpu.req_valid = 1'b1;
        tick();
        cpu.req_valid = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        chk("mid_w",      32'(mem_w),         32'd0);
        chk("mid_ce",     32'(mem_ce),        32'd0);
        chk("mid_addr",   32'(mem_addr),      32'h0);
        chk("mid_wdata",  32'(mem_wdata),     32'h0);
        chk("mid_ready",  32'(cpu.req_ready), 32'd0);
        chk("mid_rsp",    32'(cpu.rsp_valid), 32'd0);
        chk("mid_rdata",  32'(cpu.rsp_rdata), 32'h0);
        chk("mid_oe",     32'(mem_oe),        32'd0);
        chk("mid_memrst", 32'(mem_rst),       32'd1);
        tick();
        rst = 1'b1;
        #1;
        chk("aft_ready",  32'(cpu.req_ready), 32'd1);
        chk("aft_rsp",    32'(cpu.rsp_valid), 32'd0);
        chk("aft_rdata",  32'(cpu.rsp_rdata), 32'h0);
        chk("aft_ce",     32'(mem_ce),        32'd0);
        tick();
        chk("aft_rsp2",   32'(cpu.rsp_valid), 32'd0);
        tick();
        chk("aft_rsp3",   32'(cpu.rsp_valid), 32'd0);
        chk("mem_40", 32'(mem_arr[16'h0040]), 32'h34);
        chk("mem_41", 32'(mem_arr[16'h0041]), 32'h00);
        do_req(1'b0, 1'b0, 16'h0040, 16'h0000, 3, "br40");
        chk("br40_data", 32'(got_rdata), 32'h0034);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
